cs_package_out_serializer: RTL and testbench
============================================

# cs_package_out_serializer

Unpacks the 2048-bit reconstructed block package that the compressed-sensing Walsh/IFWHT intra-prediction core presents on `PACKAGE_OUT`/`DATA_AVAILABLE_FLAG`. It emits the package as a ready/valid stream of 16-bit words, tagged with the block row/column position and the prediction mode. It sits at the output of the prediction core and feeds the reconstruction writer / frame store. It tracks the 45×80 block raster and flags end of frame.

## Interface
- `DATA_WIDTH`, 16, width of one sample word
- `MAX_WORDS`, 128, words per package (`DATA_WIDTH*MAX_WORDS` = 2048)
- `BLOCK_COLS`, 80, blocks per row
- `BLOCK_ROWS`, 45, block rows per frame
- `CLK`  in  1  single clock; all logic on rising edge
- `RST`  in  1  reset, synchronous and active-high
- `MODES`  in  2  word count: 00 → 64, 01 → 128, 10/11 → 128 (reserved); sampled at capture
- `DATA_AVAILABLE_FLAG`  in  1  core output-valid; a rising edge marks a new package
- `PACKAGE_OUT`  in  2048  core output package; word k = bits [16k +: 16], LSB word first
- `PREDICTION_MODE`  in  3  mode of the package; sampled at capture
- `WORD_OUT`  out  16  current sample word
- `WORD_VALID`  out  1  `WORD_OUT` valid
- `WORD_READY`  in  1  downstream accept
- `WORD_INDEX`  out  7  index k of `WORD_OUT`
- `WORD_LAST`  out  1  high with the final word of the package
- `BLK_ROW`  out  8  row of the package being streamed
- `BLK_COL`  out  8  column of the package being streamed
- `BLK_MODE`  out  3  captured `PREDICTION_MODE`
- `BUSY`  out  1  a package is held (state ≠ IDLE)
- `FRAME_DONE`  out  1  one-cycle pulse after the last word of block (44,79) is accepted
- `OVERRUN_ERR`  out  1  sticky; a package arrived while BUSY

## Operation
- Edge detect: `dav_q` registers `DATA_AVAILABLE_FLAG`. `new_pkg = DATA_AVAILABLE_FLAG & ~dav_q`. A level held high produces a single event.
- States:
  - **IDLE**
    - On `new_pkg`: capture `PACKAGE_OUT` into a 2048-bit holding register; capture `PREDICTION_MODE` into `BLK_MODE`.
    - Set word limit N = 64 or 128 from `MODES`; set `WORD_INDEX` = 0.
    - Go to STREAM.
  - **STREAM**
    - `WORD_VALID` = 1; `WORD_OUT` = hold[16·`WORD_INDEX` +: 16]; `WORD_LAST` = (`WORD_INDEX` == N−1).
    - A transfer occurs on a cycle where `WORD_VALID` & `WORD_READY`. `WORD_OUT`, `WORD_INDEX` and the tags stay stable until a transfer.
    - On a transfer with `WORD_LAST` = 0: increment `WORD_INDEX`.
    - On a transfer with `WORD_LAST` = 1: go to ADVANCE.
  - **ADVANCE** (one cycle, `WORD_VALID` = 0)
    - If `BLK_COL` < 79: `BLK_COL`++.
    - Else `BLK_COL` = 0, and: if `BLK_ROW` < 44, `BLK_ROW`++; else `BLK_ROW` = 0 and `FRAME_DONE` = 1 for the next cycle only.
    - Go to IDLE.
- Overrun: a `new_pkg` seen in STREAM or ADVANCE is discarded. The holding register is not changed. `OVERRUN_ERR` is set and stays set until `RST`.
- `new_pkg` in the same cycle that ADVANCE returns to IDLE is also an overrun. The core must wait for `BUSY` = 0.
- `BLK_ROW`/`BLK_COL` give the position of the held package. They change only in ADVANCE.

## Timing
- Reset values:
  - `WORD_OUT` = 0, `WORD_VALID` = 0, `WORD_INDEX` = 0, `WORD_LAST` = 0.
  - `BLK_ROW` = 0, `BLK_COL` = 0, `BLK_MODE` = 0.
  - `BUSY` = 0, `FRAME_DONE` = 0, `OVERRUN_ERR` = 0.
  - `dav_q` = 0, holding register = 0, state IDLE.
- If `DATA_AVAILABLE_FLAG` is already high when `RST` falls, that counts as a rising edge on the first cycle.
- Latency: `DATA_AVAILABLE_FLAG` is sampled high at edge E after being low at E−1. The package is captured at E. `WORD_VALID` and `BUSY` are high from E+1.
- Throughput: with `WORD_READY` tied high, the stream takes N cycles, then 1 ADVANCE cycle. The block accepts its next package on the following cycle. A 128-word package therefore occupies 129 cycles plus 1 capture cycle.
- Reset mid-stream (`RST` high for ≥ 1 edge):
  - The held package is dropped and all outputs return to their reset values at that edge.
  - No partial `WORD_LAST` is produced.
  - The raster restarts at (0,0).
- `WORD_VALID` never deasserts without a transfer, except on reset.

## Test plan
- Reset, `MODES` = 01, package word k = 0x1000+k, `PREDICTION_MODE` = 2, pulse `DATA_AVAILABLE_FLAG` one cycle, `WORD_READY` = 1 → 128 words 0x1000…0x107F on consecutive cycles starting one cycle after capture. `WORD_LAST` only on word 0x107F. `BLK_MODE` = 2, (row,col) = (0,0), then `BLK_COL` = 1.
- `MODES` = 00, same package → exactly 64 words, the last being 0x103F with `WORD_LAST`; words 64–127 never appear.
- Back-pressure: `WORD_READY` toggled at random at 50% → `WORD_OUT`/`WORD_INDEX` hold while `WORD_READY` = 0; all 128 words are delivered in order, with no duplicates or drops.
- Overrun: second `DATA_AVAILABLE_FLAG` rising edge at word 10 of a package → `OVERRUN_ERR` = 1 and stays 1; the stream continues with the original data; the block count advances once only.
- Raster: 3600 packages with `WORD_READY` = 1 → `BLK_COL` wraps 79→0 with `BLK_ROW`++. A single `FRAME_DONE` pulse follows package (44,79). Counters return to (0,0).
- `RST` asserted at word 50 → the next cycle shows `WORD_VALID` = 0, `BUSY` = 0, (0,0), `OVERRUN_ERR` = 0. A new package then streams from word 0.

Source files
------------

// File: rtl/cs_package_out_serializer_if.sv
// ---------------------------------------------------------------------------
// cs_package_out_serializer_if
// Word stream from the package serializer to the reconstruction writer.
//   WORD_OUT    sample word currently offered
//   WORD_VALID  WORD_OUT and the tags below are valid
//   WORD_READY  downstream accepts the offered word (driven by the sink)
//   WORD_INDEX  position k of WORD_OUT inside the package
//   WORD_LAST   final word of the package
//   BLK_ROW     block row of the package being streamed
//   BLK_COL     block column of the package being streamed
//   BLK_MODE    prediction mode captured with the package
// master = serializer side, slave = downstream side.
// ---------------------------------------------------------------------------
interface cs_package_out_serializer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 7
) ();
  logic [DATA_WIDTH-1:0] WORD_OUT;
  logic                  WORD_VALID;
  logic                  WORD_READY;
  logic [IDX_W-1:0]      WORD_INDEX;
  logic                  WORD_LAST;
  logic [7:0]            BLK_ROW;
  logic [7:0]            BLK_COL;
  logic [2:0]            BLK_MODE;

  modport master (
    output WORD_OUT, WORD_VALID, WORD_INDEX, WORD_LAST,
    output BLK_ROW, BLK_COL, BLK_MODE,
    input  WORD_READY
  );

  modport slave (
    input  WORD_OUT, WORD_VALID, WORD_INDEX, WORD_LAST,
    input  BLK_ROW, BLK_COL, BLK_MODE,
    output WORD_READY
  );
endinterface

// File: rtl/cs_package_out_serializer.sv
// ---------------------------------------------------------------------------
// cs_package_out_serializer
// Captures the wide reconstructed block package from the prediction core on a
// rising edge of DATA_AVAILABLE_FLAG and replays it as a ready/valid stream of
// DATA_WIDTH-bit words, LSB word first, tagged with block raster position and
// prediction mode. Tracks the BLOCK_ROWS x BLOCK_COLS raster and flags the
// end of each frame.
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   MODES                word count select (00 -> MAX_WORDS/2, else MAX_WORDS)
//   DATA_AVAILABLE_FLAG  core output-valid; rising edge = new package
//   PACKAGE_OUT          core package, word k = bits [DATA_WIDTH*k +: DATA_WIDTH]
//   PREDICTION_MODE      mode of the package, captured with it
//   word                 word stream interface (master side)
//   BUSY                 a package is held
//   FRAME_DONE           one-cycle pulse after the last block of a frame
//   OVERRUN_ERR          sticky: a package arrived while busy
// ---------------------------------------------------------------------------
module cs_package_out_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WORDS  = 128,
  parameter int BLOCK_COLS = 80,
  parameter int BLOCK_ROWS = 45
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [1:0]                      MODES,
  input  logic                            DATA_AVAILABLE_FLAG,
  input  logic [DATA_WIDTH*MAX_WORDS-1:0] PACKAGE_OUT,
  input  logic [2:0]                      PREDICTION_MODE,
  cs_package_out_serializer_if.master     word,
  output logic                            BUSY,
  output logic                            FRAME_DONE,
  output logic                            OVERRUN_ERR
);

  localparam int IDX_W = $clog2(MAX_WORDS);
  localparam int PKG_W = DATA_WIDTH * MAX_WORDS;

  localparam logic [IDX_W-1:0] LAST_FULL = IDX_W'(MAX_WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_HALF = IDX_W'(MAX_WORDS / 2 - 1);
  localparam logic [7:0]       LAST_COL  = 8'(BLOCK_COLS - 1);
  localparam logic [7:0]       LAST_ROW  = 8'(BLOCK_ROWS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STREAM  = 2'd1,
    ADVANCE = 2'd2
  } state_t;

  state_t           state;
  logic             dav_q;
  logic [PKG_W-1:0] hold;
  logic [IDX_W-1:0] last_idx;

  logic             new_pkg;
  logic             xfer;
  logic [IDX_W-1:0] next_idx;

  // A level held high on the core side yields exactly one capture event.
  assign new_pkg  = DATA_AVAILABLE_FLAG & ~dav_q;
  assign xfer     = word.WORD_VALID & word.WORD_READY;
  assign next_idx = word.WORD_INDEX + IDX_W'(1);

  // Capture / stream / raster-advance sequencer with registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= IDLE;
      dav_q           <= 1'b0;
      hold            <= '0;
      last_idx        <= '0;
      word.WORD_OUT   <= '0;
      word.WORD_VALID <= 1'b0;
      word.WORD_INDEX <= '0;
      word.WORD_LAST  <= 1'b0;
      word.BLK_ROW    <= 8'd0;
      word.BLK_COL    <= 8'd0;
      word.BLK_MODE   <= 3'd0;
      BUSY            <= 1'b0;
      FRAME_DONE      <= 1'b0;
      OVERRUN_ERR     <= 1'b0;
    end else begin
      dav_q      <= DATA_AVAILABLE_FLAG;
      FRAME_DONE <= 1'b0;

      // Packages arriving while one is held (including the ADVANCE cycle)
      // are dropped; only the sticky flag records them.
      if (new_pkg && (state != IDLE)) begin
        OVERRUN_ERR <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (new_pkg) begin
            hold            <= PACKAGE_OUT;
            word.BLK_MODE   <= PREDICTION_MODE;
            last_idx        <= (MODES == 2'b00) ? LAST_HALF : LAST_FULL;
            word.WORD_INDEX <= '0;
            word.WORD_OUT   <= PACKAGE_OUT[DATA_WIDTH-1:0];
            word.WORD_LAST  <= 1'b0;
            word.WORD_VALID <= 1'b1;
            BUSY            <= 1'b1;
            state           <= STREAM;
          end
        end

        STREAM: begin
          if (xfer) begin
            if (word.WORD_LAST) begin
              word.WORD_VALID <= 1'b0;
              word.WORD_LAST  <= 1'b0;
              state           <= ADVANCE;
            end else begin
              // Preload the following word so WORD_OUT stays a register.
              word.WORD_INDEX <= next_idx;
              word.WORD_OUT   <= hold[next_idx*DATA_WIDTH +: DATA_WIDTH];
              word.WORD_LAST  <= (next_idx == last_idx);
            end
          end
        end

        ADVANCE: begin
          if (word.BLK_COL < LAST_COL) begin
            word.BLK_COL <= word.BLK_COL + 8'd1;
          end else begin
            word.BLK_COL <= 8'd0;
            if (word.BLK_ROW < LAST_ROW) begin
              word.BLK_ROW <= word.BLK_ROW + 8'd1;
            end else begin
              word.BLK_ROW <= 8'd0;
              FRAME_DONE   <= 1'b1;
            end
          end
          BUSY  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          word.WORD_VALID <= 1'b0;
          word.WORD_LAST  <= 1'b0;
          BUSY            <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cs_package_out_serializer.sv
// ---------------------------------------------------------------------------
// tb_cs_package_out_serializer
// Self-checking bench. The main instance (128-word packages) is checked
// against a queue of expected word transfers built from the package contents;
// raster tags come from the package count since reset. A second instance with
// 4-word packages walks a full 45x80 frame to check raster wrap and FRAME_DONE.
// ---------------------------------------------------------------------------
module tb_cs_package_out_serializer;

  localparam int COLS = 80;
  localparam int ROWS = 45;

  logic          clk;
  logic          rst;
  logic [1:0]    modes;
  logic          dav;
  logic [2047:0] pkg;
  logic [2:0]    pmode;
  logic          busy;
  logic          fd;
  logic          ovr;

  logic [1:0]    r_modes;
  logic          r_dav;
  logic [63:0]   r_pkg;
  logic [2:0]    r_pmode;
  logic          r_busy;
  logic          r_fd;
  logic          r_ovr;

  cs_package_out_serializer_if #(.DATA_WIDTH(16), .IDX_W(7)) wi ();
  cs_package_out_serializer_if #(.DATA_WIDTH(16), .IDX_W(2)) wr ();

  cs_package_out_serializer u_dut (
    .CLK(clk), .RST(rst), .MODES(modes), .DATA_AVAILABLE_FLAG(dav),
    .PACKAGE_OUT(pkg), .PREDICTION_MODE(pmode), .word(wi),
    .BUSY(busy), .FRAME_DONE(fd), .OVERRUN_ERR(ovr)
  );

  cs_package_out_serializer #(.MAX_WORDS(4)) u_raster (
    .CLK(clk), .RST(rst), .MODES(r_modes), .DATA_AVAILABLE_FLAG(r_dav),
    .PACKAGE_OUT(r_pkg), .PREDICTION_MODE(r_pmode), .word(wr),
    .BUSY(r_busy), .FRAME_DONE(r_fd), .OVERRUN_ERR(r_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [6:0]  idx;
    logic        last;
    logic [7:0]  row;
    logic [7:0]  col;
    logic [2:0]  mode;
  } xfer_t;

  xfer_t exp_q[$];
  int    checks  = 0;
  int    errors  = 0;
  int    n_xfer  = 0;
  int    fd_main = 0;
  int    m_cnt   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the words the package should produce, then pulse the valid flag.
  task automatic send_pkg();
    int    n;
    xfer_t e;
    n = (modes == 2'b00) ? 64 : 128;
    for (int k = 0; k < n; k++) begin
      e.data = pkg[16*k +: 16];
      e.idx  = 7'(k);
      e.last = (k == n - 1);
      e.row  = 8'((m_cnt / COLS) % ROWS);
      e.col  = 8'(m_cnt % COLS);
      e.mode = pmode;
      exp_q.push_back(e);
    end
    m_cnt++;
    dav = 1'b1;
    tick();
    dav = 1'b0;
    @(negedge clk);
    check("latency_valid", wi.WORD_VALID, 1);
    check("latency_busy", busy, 1);
  endtask

  // Drive WORD_READY each cycle until the package is released. ev_kind 1
  // injects a second package, ev_kind 2 a reset, once WORD_INDEX == ev_idx.
  task automatic run_stream(input bit rnd, input int ev_kind, input int ev_idx);
    int n;
    bit fired;
    bit pend;
    n = 0; fired = 1'b0; pend = 1'b0;
    while (1) begin
      tick();
      wi.WORD_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      dav = 1'b0;
      rst = 1'b0;
      if (pend) begin
        if (ev_kind == 1) dav = 1'b1;
        else rst = 1'b1;
        pend = 1'b0;
      end
      @(negedge clk);
      if (!busy) break;
      if (!fired && ev_kind != 0 && wi.WORD_VALID && wi.WORD_INDEX == 7'(ev_idx)) begin
        fired = 1'b1;
        pend  = 1'b1;
      end
      n++;
      if (n > 2000) begin
        check("stream_timeout", busy, 0);
        break;
      end
    end
  endtask

  task automatic rand_pkg();
    for (int k = 0; k < 64; k++) pkg[32*k +: 32] = $urandom();
  endtask

  // Stream monitor: every accepted word against the expected queue, plus
  // hold-while-stalled and no-early-drop of WORD_VALID.
  initial begin
    bit          p_valid;
    bit          p_stall;
    bit          p_xlast;
    logic [15:0] p_word;
    logic [6:0]  p_idx;
    xfer_t       e;
    p_valid = 1'b0; p_stall = 1'b0; p_xlast = 1'b0; p_word = '0; p_idx = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_valid = 1'b0; p_stall = 1'b0; p_xlast = 1'b0;
      end else begin
        if (p_valid) check("valid_hold", wi.WORD_VALID, !p_xlast);
        if (p_stall) begin
          check("stall_word", wi.WORD_OUT, p_word);
          check("stall_index", wi.WORD_INDEX, p_idx);
        end
        if (fd) fd_main++;
        if (wi.WORD_VALID && wi.WORD_READY) begin
          check("queue_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("word", wi.WORD_OUT, e.data);
            check("index", wi.WORD_INDEX, e.idx);
            check("last", wi.WORD_LAST, e.last);
            check("row", wi.BLK_ROW, e.row);
            check("col", wi.BLK_COL, e.col);
            check("mode", wi.BLK_MODE, e.mode);
            n_xfer++;
          end
        end
        p_valid = wi.WORD_VALID;
        p_stall = wi.WORD_VALID && !wi.WORD_READY;
        p_xlast = wi.WORD_VALID && wi.WORD_READY && wi.WORD_LAST;
        p_word  = wi.WORD_OUT;
        p_idx   = wi.WORD_INDEX;
      end
    end
  end

  initial begin
    int base;
    int w;
    rst = 1'b1; dav = 1'b0; modes = 2'b00; pmode = 3'd0; pkg = '0;
    wi.WORD_READY = 1'b0;
    r_dav = 1'b1; r_modes = 2'b00; r_pmode = 3'd5; r_pkg = 64'h1234_5678_9abc_def0;
    wr.WORD_READY = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_valid", wi.WORD_VALID, 0);
    check("rst_word", wi.WORD_OUT, 0);
    check("rst_index", wi.WORD_INDEX, 0);
    check("rst_last", wi.WORD_LAST, 0);
    check("rst_pos", {wi.BLK_ROW, wi.BLK_COL, wi.BLK_MODE}, 0);
    check("rst_status", {busy, fd, ovr}, 0);
    check("rst_r_busy", r_busy, 0);
    rst = 1'b0;

    // Flag already high when reset falls: counts as a new package.
    @(negedge clk);
    check("dav_high_at_reset", r_busy, 1);
    check("dav_high_word0", wr.WORD_OUT, 16'hdef0);
    r_dav = 1'b0;

    // Fixed 128-word package, ready held high.
    for (int k = 0; k < 128; k++) pkg[16*k +: 16] = 16'(16'h1000 + k);
    modes = 2'b01; pmode = 3'd2; wi.WORD_READY = 1'b1;
    base = n_xfer;
    send_pkg();
    run_stream(1'b0, 0, 0);
    check("count_128", n_xfer - base, 128);
    check("col_after_first", wi.BLK_COL, 1);

    // Same package, 64-word mode.
    modes = 2'b00;
    base = n_xfer;
    send_pkg();
    run_stream(1'b0, 0, 0);
    check("count_64", n_xfer - base, 64);

    // Random back-pressure.
    rand_pkg(); modes = 2'b01; pmode = 3'($urandom_range(0, 7));
    base = n_xfer;
    send_pkg();
    run_stream(1'b1, 0, 0);
    check("count_bp", n_xfer - base, 128);

    // Overrun at word 10: original data continues, raster advances once.
    rand_pkg(); modes = 2'b01; pmode = 3'($urandom_range(0, 7));
    base = n_xfer;
    send_pkg();
    rand_pkg();
    run_stream(1'b0, 1, 10);
    check("count_overrun", n_xfer - base, 128);
    check("overrun_set", ovr, 1);
    check("col_after_overrun", wi.BLK_COL, 8'(m_cnt % COLS));

    // A few random packages (all MODES codes, random ready).
    for (int i = 0; i < 5; i++) begin
      rand_pkg(); modes = 2'($urandom_range(0, 3)); pmode = 3'($urandom_range(0, 7));
      base = n_xfer;
      send_pkg();
      run_stream(1'b1, 0, 0);
      check("count_rand", n_xfer - base, (modes == 2'b00) ? 64 : 128);
    end
    check("overrun_sticky", ovr, 1);

    // Reset at word 50.
    rand_pkg(); modes = 2'b01; pmode = 3'd6;
    send_pkg();
    run_stream(1'b0, 2, 50);
    check("mid_rst_valid", wi.WORD_VALID, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pos", {wi.BLK_ROW, wi.BLK_COL}, 0);
    check("mid_rst_ovr", ovr, 0);
    check("mid_rst_last", wi.WORD_LAST, 0);
    exp_q.delete();
    m_cnt = 0;
    rand_pkg(); modes = 2'b01; pmode = 3'd1;
    base = n_xfer;
    send_pkg();
    run_stream(1'b1, 0, 0);
    check("count_after_rst", n_xfer - base, 128);
    check("drain", exp_q.size(), 0);
    check("no_frame_done_main", fd_main, 0);

    // Full frame on the small-package instance.
    for (int p = 0; p < ROWS * COLS; p++) begin
      r_pkg   = {$urandom(), $urandom()};
      r_pmode = 3'($urandom_range(0, 7));
      r_dav = 1'b1;
      tick();
      r_dav = 1'b0;
      @(negedge clk);
      check("r_row", wr.BLK_ROW, 8'(p / COLS));
      check("r_col", wr.BLK_COL, 8'(p % COLS));
      check("r_word0", wr.WORD_OUT, r_pkg[15:0]);
      check("r_mode", wr.BLK_MODE, r_pmode);
      w = 0;
      while (r_busy && w < 20) begin
        @(negedge clk);
        w++;
      end
      check("r_idle", r_busy, 0);
      check("r_frame_done", r_fd, p == ROWS * COLS - 1);
    end
    @(negedge clk);
    check("r_frame_pulse_end", r_fd, 0);
    check("r_wrap_pos", {wr.BLK_ROW, wr.BLK_COL}, 0);
    check("r_no_overrun", r_ovr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
